// File: rtl/q_meter_pkg.sv
// ============================================================================
// Module : q_meter_pkg
// Brief  : Shared defaults, FSM state and measurement record for q_pulse_meter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package q_meter_pkg;

    localparam int CNT_W_DEF = 8;
    localparam int DEPTH_DEF = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HIGH = 1'b1
    } state_t;

    typedef struct packed {
        logic                 sat;
        logic [CNT_W_DEF-1:0] width;
    } meas_t;

endpackage

`default_nettype wire

// File: rtl/q_pulse_meter_fifo.sv
// ============================================================================
// Module : meas_fifo
// Brief  : Synchronous first-word-fall-through FIFO for pulse measurements.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module meas_fifo
    import q_meter_pkg::*;
#(
    parameter type T     = meas_t,
    parameter int  DEPTH = DEPTH_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  T     push_data,
    input  logic ready,
    output T     head,
    output logic valid,
    output logic full,
    output logic drop
);

    localparam int PTR_W = $clog2(DEPTH);

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             empty;
    logic             pop;
    logic             wr_en;

    assign empty = (count == '0);
    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign valid = ~empty;
    assign pop   = ready & ~empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign wr_en = push & (~full | pop);
    assign drop  = push & full & ~pop;
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/q_pulse_meter.sv
// ============================================================================
// Module : q_pulse_meter
// Brief  : Measures high-pulse widths of an SR flip-flop Q output into a FIFO.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module q_pulse_meter
    import q_meter_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             q_in,
    output logic [CNT_W-1:0] meas_width,
    output logic             meas_sat,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic             busy,
    output logic             edge_rise,
    output logic             edge_fall,
    output logic             overflow
);

    typedef struct packed {
        logic             sat;
        logic [CNT_W-1:0] width;
    } entry_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    logic             q_d;
    logic [CNT_W-1:0] cnt;
    logic             sat;
    logic             rise;
    logic             fall;
    logic             push;
    logic             drop;
    logic             full;
    logic             fifo_valid;
    entry_t           push_data;
    entry_t           head;

    assign rise      = q_in & ~q_d;
    assign fall      = ~q_in & q_d;
    // The push happens on the edge that samples the fall so the entry is visible one cycle later.
    assign push      = (state == HIGH) & fall;
    assign push_data = '{sat: sat, width: cnt};

    always_ff @(posedge clk) begin
        if (rst) begin
            q_d       <= 1'b0;
            state     <= IDLE;
            cnt       <= '0;
            sat       <= 1'b0;
            busy      <= 1'b0;
            edge_rise <= 1'b0;
            edge_fall <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            q_d       <= q_in;
            edge_rise <= rise;
            edge_fall <= fall;
            if (drop) begin
                overflow <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (rise) begin
                        state <= HIGH;
                        cnt   <= CNT_W'(1);
                        sat   <= (CNT_W == 1);
                        busy  <= 1'b1;
                    end
                end
                HIGH: begin
                    if (q_in) begin
                        if (cnt != CNT_MAX) begin
                            cnt <= cnt + 1'b1;
                        end
                        if (cnt >= CNT_MAX - 1'b1) begin
                            sat <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    meas_fifo #(
        .T     (entry_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .ready     (meas_ready),
        .head      (head),
        .valid     (fifo_valid),
        .full      (full),
        .drop      (drop)
    );

    // Head data is forced to zero while empty so reset leaves every output at 0.
    assign meas_valid = fifo_valid;
    assign meas_width = fifo_valid ? head.width : '0;
    assign meas_sat   = fifo_valid & head.sat;

endmodule

`default_nettype wire

// File: tb/tb_q_pulse_meter.sv
// ============================================================================
// Module : tb_q_pulse_meter
// Brief  : Directed self-checking bench for q_pulse_meter (CNT_W=4, DEPTH=4).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_q_pulse_meter;

    localparam int CNT_W = 4;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             q_in = 1'b0;
    logic             meas_ready = 1'b0;
    logic [CNT_W-1:0] meas_width;
    logic             meas_sat;
    logic             meas_valid;
    logic             busy;
    logic             edge_rise;
    logic             edge_fall;
    logic             overflow;

    int checks = 0;
    int errors = 0;
    int falls  = 0;

    q_pulse_meter #(
        .CNT_W (CNT_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .q_in       (q_in),
        .meas_width (meas_width),
        .meas_sat   (meas_sat),
        .meas_valid (meas_valid),
        .meas_ready (meas_ready),
        .busy       (busy),
        .edge_rise  (edge_rise),
        .edge_fall  (edge_fall),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drives a high pulse of w samples followed by one low sample.
    task automatic pulse(input int w);
        q_in = 1'b1;
        repeat (w) tick();
        q_in = 1'b0;
        tick();
    endtask

    task automatic pop_expect(input string tag, input int w);
        chk({tag, "_valid"}, 32'(meas_valid), 32'd1);
        chk({tag, "_width"}, 32'(meas_width), 32'(w));
        meas_ready = 1'b1;
        tick();
        meas_ready = 1'b0;
    endtask

    initial begin
        // Reset and a width-3 pulse
        rst = 1'b1;
        repeat (2) tick();
        chk("rst_valid", 32'(meas_valid), 32'd0);
        chk("rst_width", 32'(meas_width), 32'd0);
        chk("rst_sat", 32'(meas_sat), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rise", 32'(edge_rise), 32'd0);
        chk("rst_fall", 32'(edge_fall), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        rst = 1'b0;
        tick();
        q_in = 1'b1;
        tick();
        chk("w3_rise1", 32'(edge_rise), 32'd1);
        chk("w3_busy1", 32'(busy), 32'd1);
        tick();
        chk("w3_rise2", 32'(edge_rise), 32'd0);
        chk("w3_busy2", 32'(busy), 32'd1);
        tick();
        chk("w3_busy3", 32'(busy), 32'd1);
        chk("w3_novalid", 32'(meas_valid), 32'd0);
        q_in = 1'b0;
        tick();
        chk("w3_fall", 32'(edge_fall), 32'd1);
        chk("w3_busy_off", 32'(busy), 32'd0);
        chk("w3_valid", 32'(meas_valid), 32'd1);
        chk("w3_width", 32'(meas_width), 32'd3);
        chk("w3_sat", 32'(meas_sat), 32'd0);
        tick();
        chk("w3_fall_off", 32'(edge_fall), 32'd0);
        chk("w3_hold", 32'(meas_width), 32'd3);
        meas_ready = 1'b1;
        tick();
        meas_ready = 1'b0;
        chk("w3_popped", 32'(meas_valid), 32'd0);

        // Width 14 stays unsaturated, 20 saturates at 15
        pulse(14);
        chk("w14_width", 32'(meas_width), 32'd14);
        chk("w14_sat", 32'(meas_sat), 32'd0);
        meas_ready = 1'b1;
        tick();
        meas_ready = 1'b0;
        pulse(20);
        chk("sat_width", 32'(meas_width), 32'd15);
        chk("sat_sat", 32'(meas_sat), 32'd1);
        meas_ready = 1'b1;
        tick();
        meas_ready = 1'b0;
        chk("sat_popped", 32'(meas_valid), 32'd0);

        // Overflow on the fifth queued pulse
        for (int i = 1; i <= 4; i++) pulse(i);
        chk("ovf_before", 32'(overflow), 32'd0);
        chk("ovf_head_stable", 32'(meas_width), 32'd1);
        pulse(5);
        chk("ovf_set", 32'(overflow), 32'd1);
        for (int i = 1; i <= 4; i++) pop_expect($sformatf("ovf_drain%0d", i), i);
        chk("ovf_empty", 32'(meas_valid), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("ovf_cleared", 32'(overflow), 32'd0);

        // Simultaneous push and pop while full
        for (int i = 1; i <= 4; i++) pulse(i);
        q_in = 1'b1;
        repeat (2) tick();
        q_in = 1'b0;
        meas_ready = 1'b1;
        tick();
        meas_ready = 1'b0;
        chk("pp_fall", 32'(edge_fall), 32'd1);
        chk("pp_ovf", 32'(overflow), 32'd0);
        pop_expect("pp_q1", 2);
        pop_expect("pp_q2", 3);
        pop_expect("pp_q3", 4);
        pop_expect("pp_q4", 2);
        chk("pp_empty", 32'(meas_valid), 32'd0);

        // Reset in the middle of a pulse
        pulse(1);
        chk("mid_queued", 32'(meas_valid), 32'd1);
        q_in = 1'b1;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_empty", 32'(meas_valid), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        tick();
        chk("mid_rise", 32'(edge_rise), 32'd1);
        repeat (2) tick();
        q_in = 1'b0;
        tick();
        chk("mid_valid", 32'(meas_valid), 32'd1);
        chk("mid_width", 32'(meas_width), 32'd3);
        meas_ready = 1'b1;
        tick();

        // Alternating input with a consumer that is always ready
        for (int i = 0; i < 16; i++) begin
            q_in = (i % 2 == 0);
            tick();
            if (edge_fall) begin
                falls++;
                chk($sformatf("alt_valid%0d", i), 32'(meas_valid), 32'd1);
                chk($sformatf("alt_width%0d", i), 32'(meas_width), 32'd1);
            end
        end
        chk("alt_count", 32'(falls), 32'd8);
        chk("alt_ovf", 32'(overflow), 32'd0);
        q_in = 1'b0;
        tick();
        chk("alt_drained", 32'(meas_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
